// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks EX/MEM destination registers, raises stall and forward selects.
// Optional feature macro: HAZARD_FORWARDING_EN (undefined = no forwarding, stall on any EX/MEM dependency).
module hazard_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_read_rs,
  input  logic        id_read_rt,
  input  logic        id_wr_en,
  input  logic [4:0]  id_wr_reg,
  input  logic        id_is_load,
  input  logic        flush,
  output logic        stall,
  output logic        issue,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic [15:0] stall_count
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_EX  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // MEM entry carries no load flag: a load in MEM is forwardable, so only EX needs it.
  logic             ex_valid;
  logic [REG_W-1:0] ex_reg;
  logic             ex_load;
  logic             mem_valid;
  logic [REG_W-1:0] mem_reg;

  logic             rs_need, rt_need;
  logic             rs_ex, rt_ex, rs_mem, rt_mem;
  logic             hazard;
  logic [SEL_W-1:0] rs_sel, rt_sel;

  // Dependency detection; register 0 is never a real dependency.
  always_comb begin
    rs_need = id_valid && id_read_rs && (id_rs != '0);
    rt_need = id_valid && id_read_rt && (id_rt != '0);
    rs_ex   = rs_need && ex_valid  && (ex_reg  == id_rs);
    rt_ex   = rt_need && ex_valid  && (ex_reg  == id_rt);
    rs_mem  = rs_need && mem_valid && (mem_reg == id_rs);
    rt_mem  = rt_need && mem_valid && (mem_reg == id_rt);
  end

  // With forwarding only load-use in EX stalls; without it any EX/MEM match stalls.
  always_comb begin
    hazard = ((rs_ex || rt_ex) && (ex_load || !FWD_EN)) ||
             ((rs_mem || rt_mem) && !FWD_EN);
    stall  = hazard && !flush;
    issue  = id_valid && !stall && !flush;
  end

  // Forward selects; EX wins over MEM, a load still in EX cannot forward.
  always_comb begin
    rs_sel = SEL_RF;
    rt_sel = SEL_RF;
    if (rs_ex && !ex_load) rs_sel = SEL_EX;
    else if (rs_mem)       rs_sel = SEL_MEM;
    if (rt_ex && !ex_load) rt_sel = SEL_EX;
    else if (rt_mem)       rt_sel = SEL_MEM;
    fwd_rs_sel = (FWD_EN && !stall) ? rs_sel : SEL_RF;
    fwd_rt_sel = (FWD_EN && !stall) ? rt_sel : SEL_RF;
  end

  // Pipeline tracking entries; a non-issued slot becomes a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_reg    <= '0;
      ex_load   <= 1'b0;
      mem_valid <= 1'b0;
      mem_reg   <= '0;
    end else begin
      mem_valid <= ex_valid;
      mem_reg   <= ex_reg;
      ex_valid  <= issue && id_wr_en && (id_wr_reg != '0);
      ex_reg    <= id_wr_reg;
      ex_load   <= id_is_load;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow HAZARD_FORWARDING_EN when defined.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_wr_reg;
  logic        id_read_rs, id_read_rt, id_wr_en, id_is_load;
  logic        flush;
  logic        stall, issue;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_read_rs(id_read_rs), .id_read_rt(id_read_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush),
    .stall(stall), .issue(issue), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rrs, input logic rrt, input logic wen,
                        input logic [4:0] wreg, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_read_rs = rrs; id_read_rt = rrt;
    id_wr_en = wen; id_wr_reg = wreg; id_is_load = ld; flush = 1'b0;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    cyc();
    rst_n = 1'b1;
  endtask

  // Holds the current decode instruction until it issues, counting stall cycles (bounded).
  task automatic run_until_issue(output int n, output bit done);
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 6 && !done; k++) begin
      if (issue === 1'b1) done = 1'b1;
      else begin
        if (stall === 1'b1) n++;
        cyc();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL reset_issue: got %0b want 1", issue); end
    total++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d/%0d want 0/0", fwd_rs_sel, fwd_rt_sel); end
    total++; if (stall_count !== 16'h0) begin bad++; $display("FAIL reset_count: got %0h want 0", stall_count); end
    cyc();
    idle();
  endtask

  task automatic test_ex_forward();
    int n;
    bit done;
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    #1;
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL add_issue: got %0b want 1", issue); end
    cyc();
    set_id(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
    #1;
    total++; if (stall !== !FWD) begin bad++; $display("FAIL sub_stall: got %0b want %0b", stall, !FWD); end
    run_until_issue(n, done);
    total++; if (done !== 1'b1 || n != (FWD ? 0 : 2)) begin bad++; $display("FAIL sub_stall_cycles: got %0d (issued %0b) want %0d", n, done, FWD ? 0 : 2); end
    total++; if (fwd_rs_sel !== (FWD ? 2'd1 : 2'd0) || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL sub_sel: got %0d/%0d want %0d/0", fwd_rs_sel, fwd_rt_sel, FWD ? 1 : 0); end
    cyc();
    set_id(1'b1, 5'd10, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    total++; if (stall !== !FWD) begin bad++; $display("FAIL or_stall: got %0b want %0b", stall, !FWD); end
    total++; if (fwd_rs_sel !== (FWD ? 2'd1 : 2'd0) || fwd_rt_sel !== (FWD ? 2'd2 : 2'd0)) begin bad++; $display("FAIL or_sel: got %0d/%0d want %0d/%0d", fwd_rs_sel, fwd_rt_sel, FWD ? 1 : 0, FWD ? 2 : 0); end
    cyc();
    idle();
  endtask

  task automatic test_priority();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    cyc();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    cyc();
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    total++; if (stall !== !FWD) begin bad++; $display("FAIL prio_stall: got %0b want %0b", stall, !FWD); end
    total++; if (fwd_rs_sel !== (FWD ? 2'd1 : 2'd0) || fwd_rt_sel !== (FWD ? 2'd1 : 2'd0)) begin bad++; $display("FAIL prio_sel: got %0d/%0d want %0d", fwd_rs_sel, fwd_rt_sel, FWD ? 1 : 0); end
    cyc();
    idle();
  endtask

  task automatic test_load_use();
    int n;
    bit done;
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
    cyc();
    set_id(1'b1, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    total++; if (stall !== 1'b1 || issue !== 1'b0) begin bad++; $display("FAIL lu_stall: got stall=%0b issue=%0b want 1/0", stall, issue); end
    total++; if (fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL lu_sel_in_stall: got %0d want 0", fwd_rt_sel); end
    run_until_issue(n, done);
    total++; if (done !== 1'b1 || n != (FWD ? 1 : 2)) begin bad++; $display("FAIL lu_cycles: got %0d (issued %0b) want %0d", n, done, FWD ? 1 : 2); end
    total++; if (fwd_rt_sel !== (FWD ? 2'd2 : 2'd0) || fwd_rs_sel !== 2'd0) begin bad++; $display("FAIL lu_sel: got %0d/%0d want 0/%0d", fwd_rs_sel, fwd_rt_sel, FWD ? 2 : 0); end
    total++; if (stall_count !== (FWD ? 16'd1 : 16'd2)) begin bad++; $display("FAIL lu_count: got %0d want %0d", stall_count, FWD ? 1 : 2); end
    cyc();
    idle();
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    cyc();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    total++; if (stall !== 1'b0 || issue !== 1'b1) begin bad++; $display("FAIL r0_stall: got stall=%0b issue=%0b want 0/1", stall, issue); end
    total++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL r0_sel: got %0d/%0d want 0/0", fwd_rs_sel, fwd_rt_sel); end
    cyc();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);
    cyc();
    set_id(1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    total++; if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL noread: got stall=%0b sel=%0d/%0d want 0 0/0", stall, fwd_rs_sel, fwd_rt_sel); end
    cyc();
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
    cyc();
    set_id(1'b1, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    flush = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || issue !== 1'b0) begin bad++; $display("FAIL flush_out: got stall=%0b issue=%0b want 0/0", stall, issue); end
    cyc();
    flush = 1'b0;
    #1;
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", stall_count); end
    total++; if (stall !== !FWD || fwd_rt_sel !== (FWD ? 2'd2 : 2'd0)) begin bad++; $display("FAIL flush_after: got stall=%0b rt_sel=%0d want %0b/%0d", stall, fwd_rt_sel, !FWD, FWD ? 2 : 0); end
    cyc();
    idle();
  endtask

  task automatic test_back_to_back();
    int n;
    bit done;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
      cyc();
      if (r == 0) begin
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
        cyc();
      end
      set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      #1;
      run_until_issue(n, done);
      total++; if (done !== 1'b1 || n != (FWD ? 1 : 2)) begin bad++; $display("FAIL b2b_cycles[%0d]: got %0d (issued %0b) want %0d", r, n, done, FWD ? 1 : 2); end
      total++; if (fwd_rs_sel !== (FWD ? 2'd2 : 2'd0)) begin bad++; $display("FAIL b2b_sel[%0d]: got %0d want %0d", r, fwd_rs_sel, FWD ? 2 : 0); end
      cyc();
    end
    idle();
    #1;
    total++; if (stall_count !== (FWD ? 16'd2 : 16'd4)) begin bad++; $display("FAIL b2b_count: got %0d want %0d", stall_count, FWD ? 2 : 4); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
    cyc();
    set_id(1'b1, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mid_pre_stall: got %0b want 1", stall); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || issue !== 1'b1) begin bad++; $display("FAIL mid_post: got stall=%0b issue=%0b want 0/1", stall, issue); end
    total++; if (stall_count !== 16'd0 || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL mid_post_state: got count=%0d rt_sel=%0d want 0/0", stall_count, fwd_rt_sel); end
    cyc();
    idle();
  endtask

  task automatic test_saturation();
    int n;
    bit done;
    do_reset();
    force dut.stall_count = 16'hFFFE;
    #1;
    release dut.stall_count;
    #1;
    total++; if (stall_count !== 16'hFFFE) begin bad++; $display("FAIL sat_preload: got %0h want fffe", stall_count); end
    for (int r = 0; r < 3; r++) begin
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
      cyc();
      set_id(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      #1;
      run_until_issue(n, done);
      total++; if (done !== 1'b1 || stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold[%0d]: got %0h (issued %0b) want ffff", r, stall_count, done); end
      cyc();
    end
    rst_n = 1'b0;
    idle();
    cyc();
    rst_n = 1'b1;
    #1;
    total++; if (stall_count !== 16'h0) begin bad++; $display("FAIL sat_reset: got %0h want 0", stall_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_ex_forward();
    test_priority();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-low.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  decode stage holds an instruction
- id_rs  in  5  decode source register rs
- id_rt  in  5  decode source register rt
- id_read_rs  in  1  instruction reads rs (register-read decoder output)
- id_read_rt  in  1  instruction reads rt (register-read decoder output)
- id_wr_en  in  1  instruction writes a register
- id_wr_reg  in  5  destination register
- id_is_load  in  1  instruction is LW
- flush  in  1  squash decode instruction (taken branch/exception)
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- issue  out  1  decode instruction advances into EX this cycle
- fwd_rs_sel  out  2  rs operand source: 0 regfile, 1 EX result, 2 MEM result
- fwd_rt_sel  out  2  rt operand source, same encoding
- stall_count  out  16  saturating count of stall cycles

Function
REQ-003 Block SHALL keep two tracking entries, EX and MEM; each entry holds {valid, reg[4:0], is_load}.
REQ-004 Each rising edge: MEM <= EX; EX <= {issue & id_wr_en & (id_wr_reg!=0), id_wr_reg, id_is_load}, else an invalid entry.
REQ-005 A source "needs" register r when id_valid & read flag & (r!=0); register 0 SHALL never match.
REQ-006 A match SHALL require an entry with valid=1 and reg equal to the needed source register.
REQ-007 Load-use: stall SHALL be 1 when a needed source matches EX with EX.is_load=1 (exactly one bubble, because the load has advanced to MEM on the next cycle).
REQ-008 issue SHALL equal id_valid & !stall & !flush; combinational, zero latency.
REQ-009 flush SHALL override stall: when flush=1, stall=0 and issue=0.
REQ-010 Forward select per source: EX match (non-load) -> 1; else MEM match -> 2; else 0. EX SHALL take priority when both match.
REQ-011 Selects SHALL be 0 for sources not needed and whenever stall=1.
REQ-012 WB-stage writes SHALL not be tracked; the register file is write-before-read.
REQ-013 stall_count SHALL increment on every cycle with stall=1 and saturate at 16'hFFFF (no wrap).
REQ-014 Back-to-back loads to the same register SHALL each produce an independent single-cycle stall for a dependent consumer.
REQ-015 All outputs other than stall_count SHALL be combinational from inputs and entries.

Reset
REQ-016 With rst_n=0 at a clock edge: both entries invalid and stall_count=0. After that edge, stall=0, issue=id_valid&!flush, and selects=0 until new entries are issued.
REQ-017 Reset mid-stall SHALL drop the pending hazard; the next cycle issues with no stall.

Configuration
REQ-018 Macro HAZARD_FORWARDING_EN: when defined, behaviour is per REQ-007..REQ-011.
REQ-019 When HAZARD_FORWARDING_EN is undefined: fwd_rs_sel=fwd_rt_sel=0 always; stall SHALL be 1 on any needed-source match in EX or MEM, regardless of is_load.

Verification
REQ-020 With forwarding: issue ADD writing $8, then SUB reading $8 as rs -> stall=0, fwd_rs_sel=1 in the SUB decode cycle.
REQ-021 Issue LW to $9, then BEQ reading $9 as rt -> stall=1 for exactly 1 cycle, stall_count 0->1, then fwd_rt_sel=2 and issue=1.
REQ-022 Issue a write to $0, then a read of $0 -> stall=0, selects 0.
REQ-023 Load-use stall cycle with flush=1 -> stall=0, issue=0, EX bubble, stall_count unchanged.
REQ-024 Without the macro: ADD to $8 then read $8 -> stall=1 for 2 cycles, then issue with selects 0.
REQ-025 Preload stall_count=16'hFFFE and force 3 stall cycles -> stall_count holds at 16'hFFFF; rst_n=0 -> stall_count=0.
